// File: rtl/sprite_pkg.sv
// sprite_pkg: fetch FSM encoding, register offsets and animation frame codes shared by the sprite reader and writer.
package sprite_pkg;
  typedef enum logic [2:0] {IDLE, REQ_X, CAP_X, REQ_Y, CAP_Y, REQ_M, CAP_M, COMMIT} state_t;
  localparam logic [1:0] OFF_X = 2'd0;
  localparam logic [1:0] OFF_Y = 2'd1;
  localparam logic [1:0] OFF_M = 2'd2;
  localparam logic [1:0] STANDING = 2'd0;
  localparam logic [1:0] WALK_START = 2'd1;
  localparam logic [1:0] WALK_MID = 2'd2;
  localparam logic [1:0] WALK_END = 2'd3;
endpackage

// File: rtl/sprite_hit.sv
// sprite_hit: combinational test of the current pixel against the sprite box plus glyph ROM address.
module sprite_hit #(
  parameter int DATA_WIDTH = 16,
  parameter int SPRITE_DIM = 16
) (
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] y,
  input  logic [1:0]            frame,
  input  logic [9:0]            hcount,
  input  logic [9:0]            vcount,
  output logic                  hit,
  output logic [9:0]            glyph_addr
);
  localparam int W = DATA_WIDTH + 1;
  logic [W-1:0] h, v, xs, ys;
  logic [3:0] dx, dy;
  assign h = W'(hcount);
  assign v = W'(vcount);
  assign xs = {1'b0, x};
  assign ys = {1'b0, y};
  // one extra bit keeps x+SPRITE_DIM from wrapping near the top of the range
  assign hit = h >= xs && h < xs + W'(SPRITE_DIM) && v >= ys && v < ys + W'(SPRITE_DIM);
  assign dx = hcount[3:0] - x[3:0];
  assign dy = vcount[3:0] - y[3:0];
  assign glyph_addr = hit ? {frame, dy, dx} : '0;
endmodule

// File: rtl/sprite_fetch.sv
// sprite_fetch: on vblank reads sprite X/Y/frame from memory into shadows and commits them atomically.
module sprite_fetch
  import sprite_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h1000,
  parameter int SPRITE_DIM = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vblank_start,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  input  logic [9:0]            hcount,
  input  logic [9:0]            vcount,
  output logic [DATA_WIDTH-1:0] sprite_x,
  output logic [DATA_WIDTH-1:0] sprite_y,
  output logic [1:0]            sprite_frame,
  output logic                  sprite_hit,
  output logic [9:0]            glyph_addr,
  output logic                  update
);
  state_t state, next;
  logic [DATA_WIDTH-1:0] shadow_x, shadow_y;
  logic [1:0] shadow_m;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next;
  always_comb
    next = state == IDLE ? (vblank_start ? REQ_X : IDLE) :
           state == COMMIT ? IDLE : state_t'(state + 3'd1);
  always_comb begin
    mem_re = state == REQ_X || state == REQ_Y || state == REQ_M;
    mem_addr = state == REQ_X ? BASE_ADDR + ADDR_WIDTH'(OFF_X) :
               state == REQ_Y ? BASE_ADDR + ADDR_WIDTH'(OFF_Y) :
               state == REQ_M ? BASE_ADDR + ADDR_WIDTH'(OFF_M) : '0;
    update = state == COMMIT;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      shadow_x <= '0;
      shadow_y <= '0;
      shadow_m <= STANDING;
      sprite_x <= '0;
      sprite_y <= '0;
      sprite_frame <= STANDING;
    end else begin
      if (state == CAP_X) shadow_x <= mem_data_in;
      if (state == CAP_Y) shadow_y <= mem_data_in;
      // frame codes above WALK_END are not animations; show the standing pose
      if (state == CAP_M) shadow_m <= |mem_data_in[DATA_WIDTH-1:2] ? STANDING : mem_data_in[1:0];
      if (state == COMMIT) begin
        sprite_x <= shadow_x;
        sprite_y <= shadow_y;
        sprite_frame <= shadow_m;
      end
    end
  sprite_hit #(.DATA_WIDTH(DATA_WIDTH), .SPRITE_DIM(SPRITE_DIM)) u_hit (
    .x(sprite_x),
    .y(sprite_y),
    .frame(sprite_frame),
    .hcount(hcount),
    .vcount(vcount),
    .hit(sprite_hit),
    .glyph_addr(glyph_addr)
  );
endmodule

// File: tb/tb_sprite_fetch.sv
// tb_sprite_fetch: scoreboard bench; stimulus queues expected commits, a monitor checks every cycle.
module tb_sprite_fetch;
  logic clk = 0, reset = 0, vblank_start = 0;
  logic [15:0] mem_data_in = 0, mem_addr, sprite_x, sprite_y;
  logic mem_re, sprite_hit, update;
  logic [9:0] hcount = 0, vcount = 0, glyph_addr;
  logic [1:0] sprite_frame;
  typedef struct {int x; int y; int f; int c;} exp_t;
  exp_t q[$];
  exp_t pend;
  logic [15:0] mem [3];
  int cyc = 0, fstart = -100, checks = 0, errors = 0;
  int cur_x = 0, cur_y = 0, cur_f = 0;
  bit pending = 0;
  sprite_fetch dut (
    .clk(clk), .reset(reset), .vblank_start(vblank_start), .mem_data_in(mem_data_in),
    .mem_addr(mem_addr), .mem_re(mem_re), .hcount(hcount), .vcount(vcount),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_frame(sprite_frame),
    .sprite_hit(sprite_hit), .glyph_addr(glyph_addr), .update(update)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (mem_re) mem_data_in = mem[int'(mem_addr) - 'h1000];
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask
  function automatic int fmap(int m);
    return m > 3 ? 0 : m;
  endfunction
  initial forever begin
    int d, h, v, hit;
    bit rd;
    @(negedge clk);
    #1;
    d = cyc - fstart;
    if (pending) begin
      cur_x = pend.x; cur_y = pend.y; cur_f = pend.f;
      pending = 0;
    end
    rd = d == 1 || d == 3 || d == 5;
    chk("mem_re", int'(mem_re), int'(rd));
    chk("mem_addr", int'(mem_addr), rd ? 'h1000 + (d - 1) / 2 : 0);
    chk("update", int'(update), int'(d == 7));
    if (update) begin
      if (q.size() == 0) chk("update_unexpected", 1, 0);
      else begin
        pend = q.pop_front();
        chk("latency", cyc, pend.c + 7);
        pending = 1;
      end
    end else if (q.size() != 0 && cyc > q[0].c + 8) begin
      chk("update_timeout", cyc, q[0].c + 7);
      void'(q.pop_front());
    end
    chk("sprite_x", int'(sprite_x), cur_x);
    chk("sprite_y", int'(sprite_y), cur_y);
    chk("sprite_frame", int'(sprite_frame), cur_f);
    h = int'(hcount);
    v = int'(vcount);
    hit = int'(h >= cur_x && h < cur_x + 16 && v >= cur_y && v < cur_y + 16);
    chk("sprite_hit", int'(sprite_hit), hit);
    chk("glyph_addr", int'(glyph_addr), hit ? cur_f * 256 + (v - cur_y) * 16 + (h - cur_x) : 0);
  end
  task automatic cycle(int h, int v, bit vb);
    @(negedge clk);
    hcount = 10'(h);
    vcount = 10'(v);
    vblank_start = vb;
    if (vb && reset && cyc > fstart + 7) begin
      fstart = cyc;
      q.push_back('{int'(mem[0]), int'(mem[1]), fmap(int'(mem[2])), cyc});
    end
  endtask
  task automatic fetch(int x, int y, int m);
    while (cyc <= fstart + 8) cycle(hcount, vcount, 0);
    mem[0] = 16'(x); mem[1] = 16'(y); mem[2] = 16'(m);
    cycle(hcount, vcount, 1);
  endtask
  task automatic settle();
    while (cyc <= fstart + 9) cycle(hcount, vcount, 0);
  endtask
  function automatic int clamp(int a);
    return a < 0 ? 0 : a > 1023 ? 1023 : a;
  endfunction
  initial begin
    mem[0] = 0; mem[1] = 0; mem[2] = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_x", int'(sprite_x), 0);
    chk("reset_update", int'(update), 0);
    reset = 1;
    fetch(100, 50, 2);
    settle();
    fetch(100, 50, 1);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 1);
    settle();
    cycle(100, 50, 0);
    #1;
    chk("dir_hit_origin", int'(sprite_hit), 1);
    chk("dir_glyph_origin", int'(glyph_addr), 256);
    cycle(116, 50, 0);
    #1;
    chk("dir_hit_right_edge", int'(sprite_hit), 0);
    chk("dir_glyph_right_edge", int'(glyph_addr), 0);
    cycle(115, 65, 0);
    #1;
    chk("dir_glyph_corner", int'(glyph_addr), 511);
    fetch(7, 9, 5);
    settle();
    chk("frame_map", int'(sprite_frame), 0);
    fetch(300, 200, 3);
    settle();
    fetch(20, 30, 1);
    while (cyc < fstart + 4) cycle(0, 0, 0);
    #2;
    reset = 0;
    q.delete();
    fstart = -100;
    cur_x = 0; cur_y = 0; cur_f = 0;
    #1;
    chk("rst_async_x", int'(sprite_x), 0);
    chk("rst_async_frame", int'(sprite_frame), 0);
    chk("rst_async_re", int'(mem_re), 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    reset = 1;
    repeat (12) cycle(0, 0, 0);
    fetch(65530, 0, 0);
    settle();
    for (int h = 0; h < 1024; h++) cycle(h, 5, 0);
    for (int i = 0; i < 30; i++) begin
      int x = $urandom_range(0, 1000), y = $urandom_range(0, 700);
      fetch(x, y, $urandom_range(0, 7));
      repeat (12) cycle(clamp(x + $urandom_range(0, 30) - 8), clamp(y + $urandom_range(0, 30) - 8),
                        $urandom_range(0, 4) == 0);
    end
    settle();
    repeat (4) cycle(0, 0, 0);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
